digit_selector: RTL and testbench



---
 rtl/digit_selector.sv | 70 +++++++
 tb/tb_digit_selector.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/digit_selector.sv
// Single-digit up/down selector for the keypad path.
// Holds one digit in 0..MAX_DIGIT, stepped by one-clock button pulses while
// enable_digit_select is high. Output comes straight from a flop.
// Optional build macro DIGIT_SELECTOR_EDGE_DETECT_EN: qualify steps on the
// rising edge of up_pulse/down_pulse instead of on their level.
module digit_selector #(
  parameter int unsigned MAX_DIGIT   = 9,
  parameter int unsigned RESET_DIGIT = 0
) (
  input  logic       clk,
  input  logic       sys_reset,
  input  logic       enable_digit_select,
  input  logic       up_pulse,
  input  logic       down_pulse,
  output logic [3:0] current_digit
);

  localparam logic [3:0] MaxDigit   = 4'(MAX_DIGIT);
  localparam logic [3:0] ResetDigit = 4'(RESET_DIGIT);

  logic       step_up;
  logic       step_down;
  logic [3:0] digit_d;

`ifdef DIGIT_SELECTOR_EDGE_DETECT_EN
  logic up_prev;
  logic down_prev;

  // Previous-value flops; run regardless of enable so a disabled edge is consumed
  always_ff @(posedge clk) begin
    if (sys_reset) begin
      up_prev   <= 1'b0;
      down_prev <= 1'b0;
    end else begin
      up_prev   <= up_pulse;
      down_prev <= down_pulse;
    end
  end

  assign step_up   = up_pulse & ~up_prev;
  assign step_down = down_pulse & ~down_prev;
`else
  assign step_up   = up_pulse;
  assign step_down = down_pulse;
`endif

  // Next digit: wrap compare happens before the add/subtract, out-of-range loads 0
  always_comb begin
    digit_d = current_digit;
    if (enable_digit_select && (step_up != step_down)) begin
      if (current_digit > MaxDigit) begin
        digit_d = 4'd0;
      end else if (step_up) begin
        digit_d = (current_digit == MaxDigit) ? 4'd0 : current_digit + 4'd1;
      end else begin
        digit_d = (current_digit == 4'd0) ? MaxDigit : current_digit - 4'd1;
      end
    end
  end

  // Digit register; reset wins over any step
  always_ff @(posedge clk) begin
    if (sys_reset) begin
      current_digit <= ResetDigit;
    end else begin
      current_digit <= digit_d;
    end
  end

endmodule

// File: tb/tb_digit_selector.sv
// Self-checking bench for digit_selector (default parameters, either build).
module tb_digit_selector;

  logic       clk = 1'b0;
  logic       sys_reset;
  logic       enable_digit_select;
  logic       up_pulse;
  logic       down_pulse;
  logic [3:0] current_digit;

  int checks = 0;
  int errors = 0;

  logic [3:0] exp_q[$];
  logic [3:0] model_digit = 4'd0;
  logic       model_up_prev = 1'b0;
  logic       model_dn_prev = 1'b0;

  always #5 clk = ~clk;

  digit_selector dut (
    .clk                (clk),
    .sys_reset          (sys_reset),
    .enable_digit_select(enable_digit_select),
    .up_pulse           (up_pulse),
    .down_pulse         (down_pulse),
    .current_digit      (current_digit)
  );

  // Reference step rule for MAX_DIGIT = 9
  function automatic logic [3:0] model_step(input logic [3:0] d, input logic en,
                                            input logic su, input logic sd);
    if (!en || (su == sd)) return d;
    if (d > 4'd9) return 4'd0;
    if (su) return (d == 4'd9) ? 4'd0 : d + 4'd1;
    return (d == 4'd0) ? 4'd9 : d - 4'd1;
  endfunction

  // Drive one clock of stimulus, push the model result, then pop and compare after the edge
  task automatic apply(input string tag, input logic rst, input logic en,
                       input logic up, input logic dn);
    logic su, sd;
    logic [3:0] exp;
    @(negedge clk);
    sys_reset           = rst;
    enable_digit_select = en;
    up_pulse            = up;
    down_pulse          = dn;
`ifdef DIGIT_SELECTOR_EDGE_DETECT_EN
    su = up & ~model_up_prev;
    sd = dn & ~model_dn_prev;
`else
    su = up;
    sd = dn;
`endif
    if (rst) begin
      model_digit   = 4'd0;
      model_up_prev = 1'b0;
      model_dn_prev = 1'b0;
    end else begin
      model_digit   = model_step(model_digit, en, su, sd);
      model_up_prev = up;
      model_dn_prev = dn;
    end
    exp_q.push_back(model_digit);
    @(posedge clk);
    #1;
    exp = exp_q.pop_front();
    checks++;
    assert (current_digit === exp) else begin
      errors++;
      $error("FAIL %s: current_digit=%0d expected=%0d", tag, current_digit, exp);
    end
  endtask

  // Compare against a fixed value taken straight from the test plan
  task automatic check_const(input string tag, input logic [3:0] exp);
    checks++;
    assert (current_digit === exp) else begin
      errors++;
      $error("FAIL %s: current_digit=%0d expected=%0d", tag, current_digit, exp);
    end
  endtask

  logic [3:0] up_seq [10];

  initial begin
    sys_reset           = 1'b1;
    enable_digit_select = 1'b0;
    up_pulse            = 1'b0;
    down_pulse          = 1'b0;
    up_seq = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd0};

    // Reset with random button activity
    for (int i = 0; i < 3; i++) begin
      apply("reset", 1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)));
      check_const("reset_const", 4'd0);
    end
    apply("reset_release", 1'b0, 1'b1, 1'b0, 1'b0);
    check_const("after_reset", 4'd0);

    // Up wrap: ten isolated pulses
    for (int i = 0; i < 10; i++) begin
      apply("up_wrap", 1'b0, 1'b1, 1'b1, 1'b0);
      check_const("up_seq", up_seq[i]);
      apply("up_idle", 1'b0, 1'b1, 1'b0, 1'b0);
    end
    check_const("up_final", 4'd0);

    // Down wrap: five pulses from 0
    for (int i = 0; i < 5; i++) begin
      apply("down_wrap", 1'b0, 1'b1, 1'b0, 1'b1);
      apply("down_idle", 1'b0, 1'b1, 1'b0, 1'b0);
    end
    check_const("down_final", 4'd5);

    // Disabled: steps discarded
    apply("dis_up", 1'b0, 1'b0, 1'b1, 1'b0);
    apply("dis_idle", 1'b0, 1'b0, 1'b0, 1'b0);
    apply("dis_down", 1'b0, 1'b0, 1'b0, 1'b1);
    apply("dis_idle", 1'b0, 1'b0, 1'b0, 1'b0);
    check_const("dis_hold", 4'd5);
    apply("reen_up", 1'b0, 1'b1, 1'b1, 1'b0);
    check_const("reen_up", 4'd6);
    apply("reen_idle", 1'b0, 1'b1, 1'b0, 1'b0);

    // Bring digit to 3, then simultaneous up+down holds
    for (int i = 0; i < 3; i++) begin
      apply("to3_down", 1'b0, 1'b1, 1'b0, 1'b1);
      apply("to3_idle", 1'b0, 1'b1, 1'b0, 1'b0);
    end
    check_const("at3", 4'd3);
    apply("simul", 1'b0, 1'b1, 1'b1, 1'b1);
    check_const("simul_hold", 4'd3);
    apply("simul_idle", 1'b0, 1'b1, 1'b0, 1'b0);

    // Reset on the same clock as an up pulse
    apply("rst_up", 1'b1, 1'b1, 1'b1, 1'b0);
    check_const("rst_up", 4'd0);
    apply("rst_idle", 1'b0, 1'b1, 1'b0, 1'b0);

    // Held input from digit 2
    for (int i = 0; i < 2; i++) begin
      apply("to2_up", 1'b0, 1'b1, 1'b1, 1'b0);
      apply("to2_idle", 1'b0, 1'b1, 1'b0, 1'b0);
    end
    check_const("at2", 4'd2);
    for (int i = 0; i < 4; i++) apply("held_up", 1'b0, 1'b1, 1'b1, 1'b0);
`ifdef DIGIT_SELECTOR_EDGE_DETECT_EN
    check_const("held_final", 4'd3);
`else
    check_const("held_final", 4'd6);
`endif
    apply("held_release", 1'b0, 1'b1, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
